// File: rtl/multicycle_adder_pkg.sv
`default_nettype none
// =============================================================================
// Module  : multicycle_adder_pkg
// Brief   : State encoding and sizing helpers shared by the multicycle adder.
// Revision: 1.0 - initial release
// =============================================================================
package multicycle_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ADD  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still gets a 1-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_adder_chunk_adder.sv
`default_nettype none
// =============================================================================
// Module  : chunk_adder
// Brief   : Combinational CHUNK-bit ripple adder from half-adder pairs; also
//           exposes the carry into the top bit for signed-overflow detection.
// Revision: 1.0 - initial release
// =============================================================================
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic w_c;
  logic w_p;
  logic w_g;
  logic w_pc;

  always_comb begin
    w_c     = cin;
    w_p     = 1'b0;
    w_g     = 1'b0;
    w_pc    = 1'b0;
    s       = '0;
    msb_cin = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) begin
        msb_cin = w_c;
      end
      w_p  = a[i] ^ b[i];
      w_g  = a[i] & b[i];
      s[i] = w_p ^ w_c;
      w_pc = w_p & w_c;
      w_c  = w_g | w_pc;
    end
    cout = w_c;
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_adder.sv
`default_nettype none
// =============================================================================
// Module  : multicycle_adder
// Brief   : WIDTH-bit adder with carry-in, CHUNK bits per cycle, valid/ready
//           on both sides. Optional ovf output via MULTICYCLE_ADDER_OVF_EN.
// Revision: 1.0 - initial release
// =============================================================================
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_msb_cin;

  // Operand chunk selected by the running index.
  always_comb begin
    w_a_chunk = r_a[CHUNK-1:0];
    w_b_chunk = r_b[CHUNK-1:0];
    for (int i = 0; i < NCHUNK; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_chunk = r_a[i*CHUNK +: CHUNK];
        w_b_chunk = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a       (w_a_chunk),
    .b       (w_b_chunk),
    .cin     (r_carry),
    .s       (w_s),
    .cout    (w_cout),
    .msb_cin (w_msb_cin)
  );

`ifdef MULTICYCLE_ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`else
  logic w_unused_msb_cin;
  assign w_unused_msb_cin = w_msb_cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[i*CHUNK +: CHUNK] <= w_s;
            end
          end
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == C_LAST_IDX) begin
            r_cout  <= w_cout;
`ifdef MULTICYCLE_ADDER_OVF_EN
            r_ovf   <= w_msb_cin ^ w_cout;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder.sv
`default_nettype none
// =============================================================================
// Module  : tb_multicycle_adder
// Brief   : Scoreboard bench for multicycle_adder (CHUNK=4 main, CHUNK=16/1).
// Revision: 1.0 - initial release
// =============================================================================
module tb_multicycle_adder;

  localparam int NCHUNK = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, cout;
  logic [15:0] sum;

  logic        sw_valid = 1'b0;
  logic        sw_cin = 1'b0;
  logic        sw_ready = 1'b1;
  logic [15:0] sw_a = '0;
  logic [15:0] sw_b = '0;
  logic        w16_in_ready, w16_out_valid, w16_cout;
  logic [15:0] w16_sum;
  logic        w1_in_ready, w1_out_valid, w1_cout;
  logic [15:0] w1_sum;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic        ovf, w16_ovf, w1_ovf;
`endif

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w16_in_ready),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(w16_out_valid), .out_ready(sw_ready),
    .sum(w16_sum), .cout(w16_cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
    , .ovf(w16_ovf)
`endif
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(w1_in_ready),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(w1_out_valid), .out_ready(sw_ready),
    .sum(w1_sum), .cout(w1_cout)
`ifdef MULTICYCLE_ADDER_OVF_EN
    , .ovf(w1_ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input int acc);
    exp_t        m;
    logic [31:0] tot;
    int          sx, sy, sgn;
    tot    = 32'(x) + 32'(y) + 32'(c);
    m.sum  = tot[15:0];
    m.cout = tot[16];
    sx     = $signed(x);
    sy     = $signed(y);
    sgn    = sx + sy + (c ? 1 : 0);
    m.ovf  = (sgn > 32767) || (sgn < -32768);
    m.acc  = acc;
    return m;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else chk("latency", cyc - q[0].acc, NCHUNK);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    @(posedge clk); #1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    if (in_ready) q.push_back(model(x, y, c, cyc + 1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c, input int stall);
    out_ready = (stall == 0);
    issue(x, y, c);
    wait_out_valid();
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic sweep(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t e;
    int   lat16 = -1;
    int   lat1 = -1;
    int   t0;
    e = model(x, y, c, 0);
    @(posedge clk); #1;
    sw_a = x; sw_b = y; sw_cin = c; sw_valid = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    sw_valid = 1'b0; sw_a = 16'($urandom); sw_b = 16'($urandom);
    for (int k = 0; k < 40 && (lat16 < 0 || lat1 < 0); k++) begin
      @(negedge clk);
      if (w16_out_valid && lat16 < 0) begin
        lat16 = cyc - t0;
        chk("c16_sum", 32'(w16_sum), 32'(e.sum));
        chk("c16_cout", 32'(w16_cout), 32'(e.cout));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("c16_ovf", 32'(w16_ovf), 32'(e.ovf));
`endif
      end
      if (w1_out_valid && lat1 < 0) begin
        lat1 = cyc - t0;
        chk("c1_sum", 32'(w1_sum), 32'(e.sum));
        chk("c1_cout", 32'(w1_cout), 32'(e.cout));
`ifdef MULTICYCLE_ADDER_OVF_EN
        chk("c1_ovf", 32'(w1_ovf), 32'(e.ovf));
`endif
      end
    end
    chk("c16_latency", lat16, 32'd1);
    chk("c1_latency", lat1, 32'd16);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h0FFF, 16'h0001, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'hFFFF, 1'b0, 1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 2);

    // Backpressure: result held while new operands are offered.
    out_ready = 1'b0;
    issue(16'h1234, 16'h4321, 1'b0);
    wait_out_valid();
    e = q[0];
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum", 32'(sum), 32'(e.sum));
      chk("bp_cout", 32'(cout), 32'(e.cout));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of ADD abandons the operation.
    issue(16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    sweep(16'hA5A5, 16'h5A5B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sweep(16'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (10) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
